// File: rtl/i2c_target_mc.sv
// i2c_target_mc: multi-channel I2C target, SCL/SDA oversampled on system_clk.
// Define I2C_STRETCH_EN to stretch SCL on rx overflow / tx underrun instead.
module i2c_target_mc #(
    parameter logic [6:0] BASE_ADDR = 7'h2A,
    parameter int         NUM_CH    = 2,
    parameter logic [7:0] UNDERRUN  = 8'hFF,
    localparam int        CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            system_clk,
    input  logic            reset,
    input  logic            scl_in,
    input  logic            sda_in,
    output logic            sda_oe,
    output logic            scl_oe,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic [7:0]      rx_data,
    output logic [CH_W-1:0] rx_chan,
    output logic            rx_first,
    output logic [CH_W-1:0] tx_chan,
    input  logic            tx_valid,
    input  logic [7:0]      tx_data,
    output logic            tx_ready,
    output logic            busy,
    output logic            underrun
);
`ifdef I2C_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      scl_sync_q, scl_sync_d;
    logic [2:0]      sda_sync_q, sda_sync_d;
    logic [7:0]      shift_q, shift_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [CH_W-1:0] chan_q, chan_d;
    logic            rw_q, rw_d;
    logic            first_q, first_d;
    logic            pend_q, pend_d;
    logic            sda_oe_q, sda_oe_d;
    logic            scl_oe_q, scl_oe_d;
    logic            rx_valid_q, rx_valid_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic [CH_W-1:0] rx_chan_q, rx_chan_d;
    logic            rx_first_q, rx_first_d;
    logic            tx_ready_q, tx_ready_d;
    logic            busy_q, busy_d;
    logic            underrun_q, underrun_d;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic       rx_free, match;
    logic [7:0] in_byte, diff;
    logic       begin_rd, ld_en, push_en;
    logic [7:0] ld_byte, push_byte;

    // [1] is the synchronised level, [2] the previous sample
    assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
    assign start_det = scl_sync_q[1] & scl_sync_q[2]
                     & sda_sync_q[2] & ~sda_sync_q[1];
    assign stop_det  = scl_sync_q[1] & scl_sync_q[2]
                     & ~sda_sync_q[2] & sda_sync_q[1];
    assign in_byte   = {shift_q[6:0], sda_sync_q[1]};
    assign diff      = {1'b0, in_byte[7:1]} - {1'b0, BASE_ADDR};
    assign match     = diff < 8'(NUM_CH);
    assign rx_free   = ~rx_valid_q | rx_ready;

    always_comb begin
        scl_sync_d = {scl_sync_q[1:0], scl_in};
        sda_sync_d = {sda_sync_q[1:0], sda_in};
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        chan_d     = chan_q;
        rw_d       = rw_q;
        first_d    = first_q;
        pend_d     = pend_q;
        sda_oe_d   = sda_oe_q;
        scl_oe_d   = scl_oe_q;
        rx_valid_d = rx_valid_q & ~rx_ready;
        rx_data_d  = rx_data_q;
        rx_chan_d  = rx_chan_q;
        rx_first_d = rx_first_q;
        tx_ready_d = 1'b0;
        busy_d     = busy_q;
        underrun_d = underrun_q;
        begin_rd   = 1'b0;
        ld_en      = 1'b0;
        ld_byte    = tx_data;
        push_en    = 1'b0;
        push_byte  = in_byte;

        // SCL is released a cycle after the stall clears so SDA leads it
        if (scl_oe_q && !pend_q) scl_oe_d = 1'b0;
        if (pend_q) begin
            if ((state_q == WR || state_q == WR_ACK) && rx_free) begin
                push_en   = 1'b1;
                push_byte = shift_q;
                pend_d    = 1'b0;
            end
            if (state_q == RD && tx_valid) begin
                ld_en      = 1'b1;
                tx_ready_d = 1'b1;
                pend_d     = 1'b0;
            end
        end

        unique case (state_q)
            IDLE: begin
            end
            ADDR: begin
                if (scl_rise && cnt_q < 4'd8) begin
                    shift_d = in_byte;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        if (match) begin
                            busy_d  = 1'b1;
                            chan_d  = diff[CH_W-1:0];
                            rw_d    = in_byte[0];
                            first_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (scl_fall && cnt_q == 4'd8) begin
                    state_d  = ADDR_ACK;
                    sda_oe_d = 1'b1;
                end
            end
            ADDR_ACK: begin
                if (scl_fall) begin
                    if (rw_q) begin
                        begin_rd = 1'b1;
                    end else begin
                        state_d  = WR;
                        cnt_d    = 4'd0;
                        sda_oe_d = 1'b0;
                    end
                end
            end
            WR: begin
                if (scl_rise && cnt_q < 4'd8) begin
                    shift_d = in_byte;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        if (rx_free) begin
                            push_en = 1'b1;
                        end else if (STRETCH) begin
                            pend_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end else if (scl_fall && cnt_q == 4'd8) begin
                    state_d  = WR_ACK;
                    sda_oe_d = 1'b1;
                    scl_oe_d = pend_d;
                end
            end
            WR_ACK: begin
                if (scl_fall) begin
                    state_d  = WR;
                    cnt_d    = 4'd0;
                    sda_oe_d = 1'b0;
                end
            end
            RD: begin
                if (scl_rise && cnt_q < 4'd8) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (scl_fall && cnt_q == 4'd8) begin
                    state_d  = RD_ACK;
                    cnt_d    = 4'd0;
                    sda_oe_d = 1'b0;
                end else if (scl_fall && cnt_q != 4'd0) begin
                    shift_d  = {shift_q[6:0], 1'b0};
                    sda_oe_d = ~shift_q[6];
                end
            end
            RD_ACK: begin
                if (scl_rise) begin
                    if (sda_sync_q[1]) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = 4'd1;
                    end
                end else if (scl_fall && cnt_q == 4'd1) begin
                    begin_rd = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (begin_rd) begin
            state_d  = RD;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            if (tx_valid) begin
                ld_en      = 1'b1;
                tx_ready_d = 1'b1;
            end else if (STRETCH) begin
                pend_d   = 1'b1;
                scl_oe_d = 1'b1;
            end else begin
                ld_en      = 1'b1;
                ld_byte    = UNDERRUN;
                underrun_d = 1'b1;
            end
        end
        if (ld_en) begin
            shift_d  = ld_byte;
            sda_oe_d = ~ld_byte[7];
        end
        if (push_en) begin
            rx_valid_d = 1'b1;
            rx_data_d  = push_byte;
            rx_chan_d  = chan_q;
            rx_first_d = first_q;
            first_d    = 1'b0;
        end
        // bus conditions win over anything the byte engine decided
        if (start_det || stop_det) begin
            state_d  = start_det ? ADDR : IDLE;
            cnt_d    = 4'd0;
            shift_d  = 8'd0;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
            scl_oe_d = 1'b0;
            pend_d   = 1'b0;
            if (start_det) underrun_d = 1'b0;
        end
    end

    always_ff @(posedge system_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            shift_q    <= 8'd0;
            cnt_q      <= 4'd0;
            chan_q     <= '0;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            pend_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_chan_q  <= '0;
            rx_first_q <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            chan_q     <= chan_d;
            rw_q       <= rw_d;
            first_q    <= first_d;
            pend_q     <= pend_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_chan_q  <= rx_chan_d;
            rx_first_q <= rx_first_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign scl_oe   = STRETCH ? scl_oe_q : 1'b0;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign rx_chan  = rx_chan_q;
    assign rx_first = rx_first_q;
    assign tx_chan  = chan_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule
